srl_rule_writer: RTL and testbench
==================================

SRL_RULE_WRITER -- requirements
Module: srl_rule_writer

Interface
REQ-001 The block SHALL have parameter NCHUNK, default 8, meaning the number of 5-bit key chunks, one SRL32 per chunk.
REQ-002 The block SHALL have parameter ENTRY_W, default 6, meaning the width of the CAM entry index.
REQ-003 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rule_valid  input  1  a rule update is offered.
REQ-006 rule_ready  output  1  the block can accept a rule.
REQ-007 rule_key  input  5*NCHUNK  key value; chunk c is bits [5c+4:5c].
REQ-008 rule_mask  input  5*NCHUNK  ternary mask; a 1 bit means don't-care.
REQ-009 rule_entry  input  ENTRY_W  target CAM entry.
REQ-010 srl_we  output  1  SRL shift enable.
REQ-011 srl_din  output  1  SRL serial data.
REQ-012 srl_sel  output  clog2(NCHUNK)  SRL chunk select.
REQ-013 srl_entry  output  ENTRY_W  entry being written, held for the whole update.
REQ-014 busy  output  1  an update is in progress.
REQ-015 done  output  1  one-cycle pulse at the end of an update.

Function
REQ-016 The block SHALL have three FSM states: IDLE, WRITE and DONE.
REQ-017 rule_ready SHALL be 1 only in IDLE.
REQ-018 A handshake SHALL occur when rule_valid and rule_ready are both 1; it SHALL latch key, mask and entry and move the FSM to WRITE.
REQ-019 Inputs SHALL be ignored outside a handshake; a change on them during WRITE SHALL have no effect.
REQ-020 WRITE SHALL last exactly 32*NCHUNK cycles, with srl_we=1 on every one of them.
REQ-021 For a handshake in cycle T, srl_we SHALL be high in cycles T+1 .. T+32*NCHUNK.
REQ-022 WRITE SHALL use a cycle counter k (0..31) and a chunk counter c (0..NCHUNK-1); srl_sel SHALL equal c.
REQ-023 k SHALL wrap from 31 to 0 and c SHALL increment on that wrap.
REQ-024 Because the SRL shifts in at address 0, the cycle with index k SHALL write the match bit for address a = 31-k.
REQ-025 srl_din SHALL be 1 iff ((a XOR key_c) AND NOT mask_c) == 0, where key_c and mask_c are chunk c of the latched key and mask.
REQ-026 srl_din SHALL be registered and aligned with srl_we; there SHALL be no combinational path from the rule_* inputs to the srl_* outputs.
REQ-027 After the last WRITE cycle (c=NCHUNK-1, k=31) the FSM SHALL enter DONE for one cycle: done=1, srl_we=0, then return to IDLE.
REQ-028 busy SHALL be 1 in WRITE and DONE.
REQ-029 The minimum spacing between handshakes SHALL be 32*NCHUNK+2 cycles.
REQ-030 A rule_valid held high through DONE SHALL be accepted in the first IDLE cycle.
REQ-031 A mask with all ones SHALL make srl_din=1 for all 32*NCHUNK cycles.
REQ-032 srl_din, srl_sel and srl_entry SHALL hold their last values while srl_we=0.
REQ-033 The stream SHALL line up with the downstream SRL select counter: 32 writes per select, select increments every 32 cycles, and the all-SRLs-filled condition occurs after 256 writes for NCHUNK=8.

Reset
REQ-034 Reset SHALL override all other inputs, including mid-WRITE.
REQ-035 On reset the FSM SHALL go to IDLE, and k, c, srl_sel, srl_entry, srl_we, srl_din, busy and done SHALL all be 0.
REQ-036 rule_ready SHALL be 0 during the reset cycle and 1 in the cycle after reset deasserts.
REQ-037 A partially written rule SHALL be abandoned on reset without a done pulse; rewriting it is the controller's responsibility.

Structure
REQ-038 A shared package SHALL hold: the FSM state enum, SRL_DEPTH=32, CHUNK_W=5, and a match-bit function (addr, key_c, mask_c) -> bit.
REQ-039 The cycle/chunk counter pair SHALL be one sub-module, srl_addr_seq (inputs: enable, clear; outputs: k, c, last).
REQ-040 The FSM, latches and data path SHALL be in the top module.

Verification
REQ-041 Exact key 0x00_0000_0000, mask 0, entry 5 -> srl_din=1 only at k=31 of every chunk (8 ones total); srl_entry=5; done at T+257.
REQ-042 Mask all ones -> srl_din=1 for all 256 cycles; srl_sel steps 0..7 every 32 cycles.
REQ-043 Chunk0 key=0x1F, mask=0x03 -> for sel=0, ones only at k=0..3 (addresses 31..28); other chunks follow their own key/mask.
REQ-044 Reset asserted at cycle T+100 of WRITE -> srl_we=0 next cycle, no done pulse, rule_ready=1 one cycle after reset releases.
REQ-045 rule_valid held high across two back-to-back rules -> second handshake exactly 258 cycles after the first; no srl_we gap other than the DONE cycle.
REQ-046 Change rule_key mid-WRITE -> output stream identical to the undisturbed run.

Source files
------------

// File: rtl/srl_rule_writer_pkg.sv
// Shared types and helpers for the SRL32-based ternary CAM rule writer.
package srl_rule_writer_pkg;

  localparam int SRL_DEPTH = 32;
  localparam int CHUNK_W   = 5;
  localparam int K_W       = $clog2(SRL_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // An SRL address matches a chunk when every non-masked bit equals the key bit.
  function automatic logic match_bit(input logic [K_W-1:0]     addr,
                                     input logic [CHUNK_W-1:0] key_c,
                                     input logic [CHUNK_W-1:0] mask_c);
    return ((addr ^ key_c) & ~mask_c) == '0;
  endfunction

endpackage

// File: rtl/srl_addr_seq.sv
// Cycle (k) and chunk (c) counter pair walking every address of every SRL.
module srl_addr_seq
  import srl_rule_writer_pkg::*;
#(
  parameter int NCHUNK = 8,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [K_W-1:0]   k,
  output logic [SEL_W-1:0] c,
  output logic             last
);

  logic k_wrap;

  assign k_wrap = (k == K_W'(SRL_DEPTH - 1));
  assign last   = k_wrap && (c == SEL_W'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k <= '0;
      c <= '0;
    end else if (enable) begin
      k <= k + 1'b1;
      if (k_wrap) c <= last ? '0 : c + 1'b1;
    end
  end

endmodule

// File: rtl/srl_rule_writer.sv
// Serialises a ternary key/mask rule into NCHUNK SRL32 columns, one match bit per cycle.
module srl_rule_writer
  import srl_rule_writer_pkg::*;
#(
  parameter  int NCHUNK  = 8,
  parameter  int ENTRY_W = 6,
  localparam int SEL_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rule_valid,
  output logic                      rule_ready,
  input  logic [CHUNK_W*NCHUNK-1:0] rule_key,
  input  logic [CHUNK_W*NCHUNK-1:0] rule_mask,
  input  logic [ENTRY_W-1:0]        rule_entry,
  output logic                      srl_we,
  output logic                      srl_din,
  output logic [SEL_W-1:0]          srl_sel,
  output logic [ENTRY_W-1:0]        srl_entry,
  output logic                      busy,
  output logic                      done
);

  state_t                    state_q, state_d;
  logic [CHUNK_W*NCHUNK-1:0] key_q, mask_q;
  logic                      handshake;
  logic [K_W-1:0]            k, k_n;
  logic [SEL_W-1:0]          c, c_n;
  logic                      last;
  logic [CHUNK_W-1:0]        key_c, mask_c;

  assign rule_ready = (state_q == IDLE) && !reset;
  assign handshake  = rule_valid && rule_ready;
  assign srl_we     = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rule_valid) state_d = WRITE;
      WRITE:   if (last)       state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  srl_addr_seq #(
    .NCHUNK (NCHUNK),
    .SEL_W  (SEL_W)
  ) u_seq (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == WRITE),
    .clear  (handshake),
    .k      (k),
    .c      (c),
    .last   (last)
  );

  // (k, c) index the bit currently on srl_din, so the register is loaded with
  // the bit for the following index; the first bit is loaded at the handshake.
  always_comb begin
    k_n = k + 1'b1;
    c_n = c;
    if (k == K_W'(SRL_DEPTH - 1)) c_n = c + 1'b1;
    key_c  = key_q[c_n*CHUNK_W +: CHUNK_W];
    mask_c = mask_q[c_n*CHUNK_W +: CHUNK_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= '0;
      mask_q    <= '0;
      srl_din   <= 1'b0;
      srl_sel   <= '0;
      srl_entry <= '0;
    end else if (handshake) begin
      key_q     <= rule_key;
      mask_q    <= rule_mask;
      srl_entry <= rule_entry;
      srl_sel   <= '0;
      srl_din   <= match_bit(K_W'(SRL_DEPTH - 1), rule_key[CHUNK_W-1:0],
                             rule_mask[CHUNK_W-1:0]);
    end else if (state_q == WRITE && !last) begin
      srl_sel <= c_n;
      srl_din <= match_bit(K_W'(SRL_DEPTH - 1) - k_n, key_c, mask_c);
    end
  end

endmodule

// File: tb/tb_srl_rule_writer.sv
// Randomised self-checking bench for srl_rule_writer against a per-address match model.
module tb_srl_rule_writer;

  localparam int NCHUNK  = 8;
  localparam int ENTRY_W = 6;
  localparam int NBITS   = 32 * NCHUNK;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rule_valid;
  logic                 rule_ready;
  logic [5*NCHUNK-1:0]  rule_key, rule_mask;
  logic [ENTRY_W-1:0]   rule_entry;
  logic                 srl_we, srl_din, busy, done;
  logic [2:0]           srl_sel;
  logic [ENTRY_W-1:0]   srl_entry;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  srl_rule_writer #(.NCHUNK(NCHUNK), .ENTRY_W(ENTRY_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rule_valid (rule_valid),
    .rule_ready (rule_ready),
    .rule_key   (rule_key),
    .rule_mask  (rule_mask),
    .rule_entry (rule_entry),
    .srl_we     (srl_we),
    .srl_din    (srl_din),
    .srl_sel    (srl_sel),
    .srl_entry  (srl_entry),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Written-bit index idx targets SRL idx/32 at address 31 - idx%32; it is 1
  // when every unmasked key bit equals the corresponding address bit.
  function automatic bit model_bit(input logic [5*NCHUNK-1:0] key,
                                   input logic [5*NCHUNK-1:0] mask, input int idx);
    int ch   = idx / 32;
    int addr = 31 - (idx % 32);
    for (int b = 0; b < 5; b++)
      if (!mask[ch*5+b] && (((addr >> b) & 1) != int'(key[ch*5+b]))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [5*NCHUNK-1:0] rnd40();
    return 40'({$urandom(), $urandom()});
  endfunction

  task automatic run_rule(input logic [5*NCHUNK-1:0] key, input logic [5*NCHUNK-1:0] mask,
                          input logic [ENTRY_W-1:0] entry, input bit keep_valid,
                          input bit scramble, output int hs, output int ones);
    logic [NBITS-1:0] exp;
    for (int i = 0; i < NBITS; i++) exp[i] = model_bit(key, mask, i);
    rule_valid = 1'b1;
    rule_key   = key;
    rule_mask  = mask;
    rule_entry = entry;
    chk("ready_at_handshake", 64'(rule_ready), 64'd1);
    @(posedge clk); #1;
    hs = cyc;
    rule_valid = keep_valid;
    ones = 0;
    for (int i = 0; i < NBITS; i++) begin
      if (scramble) begin
        rule_key   = rnd40();
        rule_mask  = rnd40();
        rule_entry = ENTRY_W'($urandom());
      end
      chk("we",    64'(srl_we),    64'd1);
      chk("din",   64'(srl_din),   64'(exp[i]));
      chk("sel",   64'(srl_sel),   64'(i / 32));
      chk("entry", 64'(srl_entry), 64'(entry));
      chk("busy",  64'(busy),      64'd1);
      chk("done_early", 64'(done), 64'd0);
      ones += int'(srl_din);
      @(posedge clk); #1;
    end
    chk("ones", 64'(ones), 64'($countones(exp)));
    chk("done_pulse", 64'(done),    64'd1);
    chk("we_in_done", 64'(srl_we),  64'd0);
    chk("busy_done",  64'(busy),    64'd1);
    chk("ready_done", 64'(rule_ready), 64'd0);
    chk("din_hold",   64'(srl_din), 64'(exp[NBITS-1]));
    chk("sel_hold",   64'(srl_sel), 64'(NCHUNK - 1));
    @(posedge clk); #1;
    chk("done_cleared", 64'(done),   64'd0);
    chk("busy_idle",    64'(busy),   64'd0);
    chk("we_idle",      64'(srl_we), 64'd0);
    chk("ready_idle",   64'(rule_ready), 64'd1);
    chk("din_hold_idle", 64'(srl_din), 64'(exp[NBITS-1]));
    chk("entry_hold",   64'(srl_entry), 64'(entry));
  endtask

  initial begin
    int hs1, hs2, ones;
    logic [5*NCHUNK-1:0] key, mask;
    logic [NBITS-1:0] exp;

    reset = 1'b1; rule_valid = 1'b1; rule_key = '1; rule_mask = '0; rule_entry = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(rule_ready), 64'd0);
    chk("rst_we",    64'(srl_we),    64'd0);
    chk("rst_din",   64'(srl_din),   64'd0);
    chk("rst_sel",   64'(srl_sel),   64'd0);
    chk("rst_entry", 64'(srl_entry), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    rule_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(rule_ready), 64'd1);
    @(posedge clk); #1;

    // Exact all-zero key: only address 0 (k=31) matches in each chunk.
    run_rule('0, '0, ENTRY_W'(5), 1'b0, 1'b0, hs1, ones);
    chk("exact_zero_ones", 64'(ones), 64'd8);

    // Full don't-care: every address matches.
    run_rule(rnd40(), '1, ENTRY_W'($urandom()), 1'b0, 1'b0, hs1, ones);
    chk("all_mask_ones", 64'(ones), 64'(NBITS));

    // Chunk 0 key 0x1F mask 0x03 matches addresses 31..28 only.
    key  = rnd40(); key[4:0]  = 5'h1F;
    mask = rnd40(); mask[4:0] = 5'h03;
    run_rule(key, mask, ENTRY_W'($urandom()), 1'b0, 1'b0, hs1, ones);

    // Random rules, inputs churning during WRITE.
    for (int r = 0; r < 4; r++)
      run_rule(rnd40(), rnd40() & rnd40(), ENTRY_W'($urandom()), 1'b0, 1'b1, hs1, ones);

    // rule_valid held high through DONE with disturbed inputs, then a second rule.
    run_rule(rnd40(), rnd40() & rnd40(), ENTRY_W'($urandom()), 1'b1, 1'b1, hs1, ones);
    run_rule(rnd40(), rnd40() & rnd40(), ENTRY_W'($urandom()), 1'b0, 1'b0, hs2, ones);
    chk("b2b_spacing", 64'(hs2 - hs1), 64'(NBITS + 2));

    // Reset in cycle T+100 of a WRITE.
    key  = rnd40();
    mask = rnd40() & rnd40();
    for (int i = 0; i < NBITS; i++) exp[i] = model_bit(key, mask, i);
    rule_valid = 1'b1; rule_key = key; rule_mask = mask; rule_entry = ENTRY_W'(9);
    @(posedge clk); #1;
    rule_valid = 1'b0;
    for (int i = 0; i < 99; i++) begin
      chk("pre_rst_din", 64'(srl_din), 64'(exp[i]));
      @(posedge clk); #1;
    end
    chk("pre_rst_we", 64'(srl_we), 64'd1);
    reset = 1'b1;
    #1;
    chk("ready_in_rst", 64'(rule_ready), 64'd0);
    @(posedge clk); #1;
    chk("abort_we",    64'(srl_we),    64'd0);
    chk("abort_busy",  64'(busy),      64'd0);
    chk("abort_done",  64'(done),      64'd0);
    chk("abort_din",   64'(srl_din),   64'd0);
    chk("abort_sel",   64'(srl_sel),   64'd0);
    chk("abort_entry", 64'(srl_entry), 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_post_rst", 64'(rule_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", 64'(done), 64'd0);
      chk("idle_we_after_abort", 64'(srl_we), 64'd0);
    end

    // Writer must be fully usable again after an aborted rule.
    run_rule(rnd40(), rnd40() & rnd40(), ENTRY_W'($urandom()), 1'b0, 1'b0, hs1, ones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
